// File: rtl/dram_req_queue.sv
// In-order request buffer in front of the DRAM controller user interface.
// Client requests are queued in a FIFO and issued one at a time; read data returns through a single response slot.
module dram_req_queue #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   u_clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_cmd,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   wr_done,
    output logic [LEVEL_WIDTH-1:0] fifo_level,
    output logic                   err_stray,
    output logic                   ctl_en,
    output logic [ADDR_WIDTH-1:0]  ctl_addr,
    output logic [DATA_WIDTH-1:0]  ctl_wdata,
    output logic                   ctl_cmd,
    input  logic                   ctl_busy,
    input  logic                   ctl_cmd_ack,
    input  logic [DATA_WIDTH-1:0]  ctl_rd_data,
    input  logic                   ctl_rd_valid
);

    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP
    } state_t;

    typedef struct packed {
        logic                  cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t                 mem_q [FIFO_DEPTH];
    entry_t                 head;
    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   full, empty, push, pop;

    state_t                 state_q;
    logic                   ctl_en_q, ctl_cmd_q, wr_done_q, rsp_valid_q, err_stray_q;
    logic [ADDR_WIDTH-1:0]  ctl_addr_q;
    logic [DATA_WIDTH-1:0]  ctl_wdata_q, rsp_rdata_q;

    // A full FIFO refuses pushes even when the head pops on the same edge.
    assign full  = (level_q == LEVEL_WIDTH'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign push  = req_valid && !full;
    assign pop   = (state_q == S_ISSUE) && ctl_cmd_ack;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
            2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge u_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{cmd: req_cmd, addr: req_addr, wdata: req_wdata};
        end
    end

    always_ff @(posedge u_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge u_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ctl_en_q    <= 1'b0;
            ctl_cmd_q   <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_wdata_q <= '0;
            wr_done_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_stray_q <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            // Read data arriving when no read is outstanding is dropped and flagged.
            if (ctl_rd_valid && (state_q != S_WAIT_RD)) begin
                err_stray_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (!empty && !ctl_busy) begin
                        ctl_cmd_q   <= head.cmd;
                        ctl_addr_q  <= head.addr;
                        ctl_wdata_q <= head.wdata;
                        ctl_en_q    <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ctl_cmd_ack) begin
                        ctl_en_q <= 1'b0;
                        if (ctl_cmd_q) begin
                            wr_done_q <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            state_q <= S_WAIT_RD;
                        end
                    end
                end
                S_WAIT_RD: begin
                    if (ctl_rd_valid) begin
                        rsp_rdata_q <= ctl_rd_data;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = !full;
    assign fifo_level = level_q;
    assign ctl_en     = ctl_en_q;
    assign ctl_cmd    = ctl_cmd_q;
    assign ctl_addr   = ctl_addr_q;
    assign ctl_wdata  = ctl_wdata_q;
    assign wr_done    = wr_done_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign err_stray  = err_stray_q;

endmodule

// File: tb/tb_dram_req_queue.sv
// Bench for dram_req_queue: cycle vector table, directed corner sequences,
// and a randomized run against a transaction-level model of queue order and response slot.
module tb_dram_req_queue;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          u_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_cmd = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          wr_done, err_stray, ctl_en, ctl_cmd;
    logic [LW-1:0] fifo_level;
    logic [AW-1:0] ctl_addr;
    logic [DW-1:0] ctl_wdata;
    logic          ctl_busy = 1'b0, ctl_cmd_ack = 1'b0, ctl_rd_valid = 1'b0;
    logic [DW-1:0] ctl_rd_data = '0;

    always #5 u_clk = ~u_clk;

    dram_req_queue #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .LEVEL_WIDTH(LW)
    ) dut (
        .u_clk       (u_clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .wr_done     (wr_done),
        .fifo_level  (fifo_level),
        .err_stray   (err_stray),
        .ctl_en      (ctl_en),
        .ctl_addr    (ctl_addr),
        .ctl_wdata   (ctl_wdata),
        .ctl_cmd     (ctl_cmd),
        .ctl_busy    (ctl_busy),
        .ctl_cmd_ack (ctl_cmd_ack),
        .ctl_rd_data (ctl_rd_data),
        .ctl_rd_valid(ctl_rd_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge u_clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = 1'b0;
        req_cmd      = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b0;
        ctl_busy     = 1'b0;
        ctl_cmd_ack  = 1'b0;
        ctl_rd_valid = 1'b0;
        ctl_rd_data  = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_en(input string name);
        int c = 0;
        while (!ctl_en && c < 50) begin
            tick();
            c++;
        end
        chk(name, ctl_en, 1);
    endtask

    task automatic ack_once();
        ctl_cmd_ack = 1'b1;
        tick();
        ctl_cmd_ack = 1'b0;
    endtask

    // One row per clock: inputs driven before the edge, expected outputs just after it.
    typedef struct {
        logic rst_n, v, cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic ack, rdv;
        logic [DW-1:0] rdd;
        logic rr;
        logic e_rdy;
        int   e_lvl;
        logic e_en, e_cmd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic e_wrd, e_rv;
        logic [DW-1:0] e_rd;
        logic e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic v, input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
        input logic ack, input logic rdv, input logic [DW-1:0] rdd, input logic rr,
        input logic e_rdy, input int e_lvl, input logic e_en, input logic e_cmd,
        input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd, input logic e_wrd,
        input logic e_rv, input logic [DW-1:0] e_rd, input logic e_err);
        vec_t t;
        t.rst_n = r; t.v = v; t.cmd = cmd; t.addr = addr; t.wd = wd;
        t.ack = ack; t.rdv = rdv; t.rdd = rdd; t.rr = rr;
        t.e_rdy = e_rdy; t.e_lvl = e_lvl; t.e_en = e_en; t.e_cmd = e_cmd;
        t.e_addr = e_addr; t.e_wd = e_wd; t.e_wrd = e_wrd;
        t.e_rv = e_rv; t.e_rd = e_rd; t.e_err = e_err;
        return t;
    endfunction

    vec_t tbl[19];

    task automatic run_table();
        //            rst v cmd addr    wd     ack rdv rdd    rr | rdy lvl en cmd addr   wd     wrd rv rd     err
        tbl[0]  = mk(0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[2]  = mk(1, 1, 1, 13'h0A5, 8'h3C, 0, 0, 8'h00, 0,   1, 1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[3]  = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 1, 1, 1, 13'h0A5, 8'h3C, 0, 0, 8'h00, 0);
        tbl[4]  = mk(1, 0, 0, 13'h000, 8'h00, 1, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 1, 0, 8'h00, 0);
        tbl[5]  = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[6]  = mk(1, 1, 1, 13'h010, 8'h77, 0, 0, 8'h00, 0,   1, 1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[7]  = mk(1, 1, 0, 13'h010, 8'h00, 0, 0, 8'h00, 0,   1, 2, 1, 1, 13'h010, 8'h77, 0, 0, 8'h00, 0);
        tbl[8]  = mk(1, 0, 0, 13'h000, 8'h00, 1, 0, 8'h00, 0,   1, 1, 0, 0, 13'h000, 8'h00, 1, 0, 8'h00, 0);
        tbl[9]  = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 1, 1, 0, 13'h010, 8'h00, 0, 0, 8'h00, 0);
        tbl[10] = mk(1, 0, 0, 13'h000, 8'h00, 1, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[11] = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[12] = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[13] = mk(1, 0, 0, 13'h000, 8'h00, 0, 1, 8'h77, 1,   1, 0, 0, 0, 13'h000, 8'h00, 0, 1, 8'h77, 0);
        tbl[14] = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 1,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[15] = mk(1, 0, 0, 13'h000, 8'h00, 0, 1, 8'h55, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 1);
        tbl[16] = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 1);
        tbl[17] = mk(0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        tbl[18] = mk(1, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0,   1, 0, 0, 0, 13'h000, 8'h00, 0, 0, 8'h00, 0);
        foreach (tbl[i]) begin
            rst_n        = tbl[i].rst_n;
            req_valid    = tbl[i].v;
            req_cmd      = tbl[i].cmd;
            req_addr     = tbl[i].addr;
            req_wdata    = tbl[i].wd;
            ctl_busy     = 1'b0;
            ctl_cmd_ack  = tbl[i].ack;
            ctl_rd_valid = tbl[i].rdv;
            ctl_rd_data  = tbl[i].rdd;
            rsp_ready    = tbl[i].rr;
            tick();
            chk($sformatf("v%0d.req_ready", i), req_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d.fifo_level", i), fifo_level, tbl[i].e_lvl);
            chk($sformatf("v%0d.ctl_en", i), ctl_en, tbl[i].e_en);
            chk($sformatf("v%0d.wr_done", i), wr_done, tbl[i].e_wrd);
            chk($sformatf("v%0d.rsp_valid", i), rsp_valid, tbl[i].e_rv);
            chk($sformatf("v%0d.err_stray", i), err_stray, tbl[i].e_err);
            if (tbl[i].e_en || !tbl[i].rst_n) begin
                chk($sformatf("v%0d.ctl_addr", i), ctl_addr, tbl[i].e_addr);
                chk($sformatf("v%0d.ctl_wdata", i), ctl_wdata, tbl[i].e_wd);
                chk($sformatf("v%0d.ctl_cmd", i), ctl_cmd, tbl[i].e_cmd);
            end
            if (tbl[i].e_rv || !tbl[i].rst_n) begin
                chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata, tbl[i].e_rd);
            end
        end
        idle_inputs();
    endtask

    task automatic seq_full();
        int got = 0;
        apply_reset();
        ctl_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full.req_ready%0d", i), req_ready, (i < 4));
            req_valid = 1'b1;
            req_cmd   = 1'b1;
            req_addr  = AW'(32'h100 + i);
            req_wdata = DW'(32'h40 + i);
            tick();
        end
        req_valid = 1'b0;
        chk("full.level", fifo_level, 4);
        chk("full.ctl_en_busy", ctl_en, 0);
        ctl_busy = 1'b0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (ctl_en) begin
                chk($sformatf("full.order_addr%0d", got), ctl_addr, 32'h100 + got);
                chk($sformatf("full.order_wd%0d", got), ctl_wdata, 32'h40 + got);
                ctl_cmd_ack = 1'b1;
                got++;
            end else begin
                ctl_cmd_ack = 1'b0;
            end
            tick();
        end
        ctl_cmd_ack = 1'b0;
        chk("full.drained", got, 4);
        tick();
        chk("full.level_end", fifo_level, 0);
        chk("full.no_fifth", ctl_en, 0);
    endtask

    task automatic seq_resp_hold();
        apply_reset();
        push(1'b0, 13'h020, 8'h00);
        push(1'b1, 13'h030, 8'h11);
        push(1'b1, 13'h031, 8'h22);
        wait_en("hold.rd_en");
        chk("hold.rd_cmd", ctl_cmd, 0);
        chk("hold.rd_addr", ctl_addr, 32'h020);
        ack_once();
        rsp_ready    = 1'b0;
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 8'hA5;
        tick();
        ctl_rd_valid = 1'b0;
        ctl_rd_data  = 8'h00;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("hold.rsp_valid%0d", i), rsp_valid, 1);
            chk($sformatf("hold.rsp_rdata%0d", i), rsp_rdata, 32'hA5);
            chk($sformatf("hold.ctl_en%0d", i), ctl_en, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hold.rsp_cleared", rsp_valid, 0);
        for (int k = 0; k < 2; k++) begin
            wait_en($sformatf("hold.wr_en%0d", k));
            chk($sformatf("hold.wr_addr%0d", k), ctl_addr, 32'h030 + k);
            chk($sformatf("hold.wr_cmd%0d", k), ctl_cmd, 1);
            chk($sformatf("hold.wr_wd%0d", k), ctl_wdata, (k == 0) ? 32'h11 : 32'h22);
            ack_once();
            chk($sformatf("hold.wr_done%0d", k), wr_done, 1);
        end
    endtask

    task automatic seq_reset_wait();
        apply_reset();
        push(1'b0, 13'h040, 8'h00);
        push(1'b1, 13'h041, 8'h01);
        push(1'b1, 13'h042, 8'h02);
        push(1'b1, 13'h043, 8'h03);
        wait_en("rst.rd_en");
        ack_once();
        chk("rst.level_before", fifo_level, 3);
        rst_n = 1'b0;
        tick();
        chk("rst.level", fifo_level, 0);
        chk("rst.ctl_en", ctl_en, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.req_ready", req_ready, 1);
        chk("rst.err_clear", err_stray, 0);
        rst_n        = 1'b1;
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 8'h99;
        tick();
        ctl_rd_valid = 1'b0;
        chk("rst.late_err", err_stray, 1);
        chk("rst.late_rsp", rsp_valid, 0);
        tick();
        chk("rst.no_issue", ctl_en, 0);
    endtask

    typedef struct packed {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    // Model: pushed requests must reach the controller in push order, one in flight at a time.
    task automatic run_random(input int cycles);
        req_t          mq[$];
        req_t          ent, nw;
        int            m_level = 0;
        logic          m_rv = 1'b0;
        logic [DW-1:0] m_rd = '0;
        logic          rd_wait = 1'b0;
        int            rd_cnt = 0;
        logic          do_push, do_pop, hs, exp_wrd;
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            req_valid    = 1'($urandom_range(0, 1));
            req_cmd      = 1'($urandom_range(0, 1));
            req_addr     = AW'($urandom);
            req_wdata    = DW'($urandom);
            ctl_busy     = ($urandom_range(0, 3) == 0);
            ctl_cmd_ack  = ctl_en && ($urandom_range(0, 2) == 0);
            ctl_rd_valid = 1'b0;
            if (rd_wait) begin
                if (rd_cnt == 0) begin
                    ctl_rd_valid = 1'b1;
                    ctl_rd_data  = DW'($urandom);
                end else begin
                    rd_cnt--;
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            do_push = req_valid && (m_level < DEPTH);
            do_pop  = ctl_cmd_ack;
            hs      = m_rv && rsp_ready;
            exp_wrd = 1'b0;
            if (do_pop) begin
                if (mq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rand.issue_without_request: got ctl_en=1 expected no request pending");
                end else begin
                    ent = mq.pop_front();
                    chk("rand.issue_cmd", ctl_cmd, ent.cmd);
                    chk("rand.issue_addr", ctl_addr, ent.addr);
                    if (ent.cmd) chk("rand.issue_wdata", ctl_wdata, ent.wd);
                    exp_wrd = ent.cmd;
                    if (!ent.cmd) begin
                        rd_wait = 1'b1;
                        rd_cnt  = $urandom_range(0, 3);
                    end
                end
            end
            nw = '{cmd: req_cmd, addr: req_addr, wd: req_wdata};
            tick();
            if (do_push) mq.push_back(nw);
            m_level = m_level + int'(do_push) - int'(do_pop);
            if (ctl_rd_valid) begin
                rd_wait = 1'b0;
                m_rv    = 1'b1;
                m_rd    = ctl_rd_data;
            end
            if (hs) m_rv = 1'b0;
            chk("rand.fifo_level", fifo_level, m_level);
            chk("rand.req_ready", req_ready, (m_level < DEPTH));
            chk("rand.wr_done", wr_done, exp_wrd);
            chk("rand.rsp_valid", rsp_valid, m_rv);
            if (m_rv) chk("rand.rsp_rdata", rsp_rdata, m_rd);
            if (ctl_en) chk("rand.single_outstanding", (rd_wait || m_rv), 0);
        end
        chk("rand.err_stray", err_stray, 0);
        idle_inputs();
    endtask

    initial begin
        run_table();
        seq_full();
        seq_resp_hold();
        seq_reset_wait();
        run_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
